// File: rtl/spi_link_pkg.sv
// spi_link_pkg: shared types and defaults for the two-phase serial configuration link.
//   rx_state_t        receiver FSM state (IDLE waiting for SCLK1, HOLD waiting for SCLK2)
//   GENERAL_REG_WIDTH width of a configuration register word
//   DATA_WIDTH_DEF    default bits per frame
//   SYNC_STAGES_DEF   default synchronizer depth
package spi_link_pkg;
  localparam int GENERAL_REG_WIDTH = 16;
  localparam int DATA_WIDTH_DEF = GENERAL_REG_WIDTH;
  localparam int SYNC_STAGES_DEF = 2;
  typedef enum logic {IDLE, HOLD} rx_state_t;
endpackage

// File: rtl/spi_2phase_rx_if.sv
// spi_2phase_rx_if: link pins and receive-side results of the two-phase serial link.
//   sclk1, sclk2, lat, sdi  link pins, driven by the transmitter (master)
//   shift_q                 live shift register contents
//   dout, dout_vld          last latched word and its one-cycle update strobe
//   bit_cnt                 bits shifted since the last LAT, saturating at DATA_WIDTH+1
//   frame_err, phase_err    sticky error flags
interface spi_2phase_rx_if
  import spi_link_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int CW = $clog2(DATA_WIDTH + 2);
  logic sclk1;
  logic sclk2;
  logic lat;
  logic sdi;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] dout;
  logic dout_vld;
  logic [CW-1:0] bit_cnt;
  logic frame_err;
  logic phase_err;
  modport master (
    output sclk1, sclk2, lat, sdi,
    input shift_q, dout, dout_vld, bit_cnt, frame_err, phase_err
  );
  modport slave (
    input sclk1, sclk2, lat, sdi,
    output shift_q, dout, dout_vld, bit_cnt, frame_err, phase_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous pin plus rising-edge detect.
//   clk, rst_n  system clock, asynchronous active-low reset
//   d           asynchronous input pin
//   q           synchronized level, delayed STAGES clocks
//   rise        one-cycle pulse when q goes 0 -> 1 (acts on the edge STAGES+1 after the pin)
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end
  assign q = sr[STAGES-1];
  assign rise = q & ~prev;
endmodule

// File: rtl/spi_2phase_rx.sv
// spi_2phase_rx: oversampling receiver for the SCLK1/SCLK2/LAT two-phase serial link.
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         spi_2phase_rx_if slave: sclk1/sclk2/lat/sdi in; shift_q, dout, dout_vld,
//               bit_cnt, frame_err, phase_err out (all registered, all reset to 0)
// SCLK1 samples SDI into a hold bit, SCLK2 shifts it in MSB-first, LAT publishes the word.
module spi_2phase_rx
  import spi_link_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic clk,
  input logic rst_n,
  spi_2phase_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] SAT = CW'(DATA_WIDTH + 1);
  logic s1, s2, sd, r1, r2, rl;
  logic lat_level_unused, sdi_rise_unused;
  rx_state_t state, st_nxt;
  logic hold_bit, pe_frame;
  logic ov, do_shift, pe_evt, clean;
  logic [DATA_WIDTH-1:0] sh_nxt;
  logic [CW-1:0] cnt_nxt;
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk1 (.clk(clk), .rst_n(rst_n), .d(bus.sclk1), .q(s1), .rise(r1));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk2 (.clk(clk), .rst_n(rst_n), .d(bus.sclk2), .q(s2), .rise(r2));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_lat (.clk(clk), .rst_n(rst_n), .d(bus.lat), .q(lat_level_unused), .rise(rl));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sdi (.clk(clk), .rst_n(rst_n), .d(bus.sdi), .q(sd), .rise(sdi_rise_unused));
  // The shift is resolved first so a LAT landing on the same cycle as SCLK2 sees the new bit.
  always_comb begin
    ov = s1 & s2;
    do_shift = r2 && state == HOLD && !ov;
    sh_nxt = do_shift ? {bus.shift_q[DATA_WIDTH-2:0], hold_bit} : bus.shift_q;
    cnt_nxt = (do_shift && bus.bit_cnt != SAT) ? bus.bit_cnt + 1'b1 : bus.bit_cnt;
    st_nxt = do_shift ? IDLE : state;
    pe_evt = ov | (r2 && state == IDLE) | (r1 && state == HOLD && !rl);
    clean = cnt_nxt == FULL && st_nxt == IDLE && !pe_frame && !pe_evt;
  end
  // pe_frame tracks phase errors within the current frame only; phase_err stays sticky
  // across a dirty LAT and is cleared only by a clean one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_bit <= 1'b0;
      pe_frame <= 1'b0;
      bus.shift_q <= '0;
      bus.dout <= '0;
      bus.dout_vld <= 1'b0;
      bus.bit_cnt <= '0;
      bus.frame_err <= 1'b0;
      bus.phase_err <= 1'b0;
    end else begin
      bus.dout_vld <= rl;
      bus.shift_q <= sh_nxt;
      if (rl) begin
        bus.dout <= sh_nxt;
        bus.bit_cnt <= '0;
        state <= IDLE;
        pe_frame <= 1'b0;
        bus.frame_err <= clean ? 1'b0 : (bus.frame_err | (cnt_nxt != FULL) | (st_nxt == HOLD));
        bus.phase_err <= !clean && (bus.phase_err | pe_evt);
      end else begin
        bus.bit_cnt <= cnt_nxt;
        pe_frame <= pe_frame | pe_evt;
        bus.phase_err <= bus.phase_err | pe_evt;
        if (r1 && !ov) begin
          hold_bit <= sd;
          state <= HOLD;
        end else begin
          state <= st_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_2phase_rx.sv
// tb_spi_2phase_rx: directed self-checking bench for spi_2phase_rx.
module tb_spi_2phase_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int vld_cnt = 0;
  int v0;
  spi_2phase_rx_if #(.DATA_WIDTH(16)) bus ();
  spi_2phase_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.dout_vld) vld_cnt++;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(logic b, bit with_lat);
    bus.sdi = b;
    wait_clk(1);
    bus.sclk1 = 1'b1;
    wait_clk(4);
    bus.sclk1 = 1'b0;
    wait_clk(4);
    bus.sclk2 = 1'b1;
    if (with_lat) bus.lat = 1'b1;
    wait_clk(4);
    bus.sclk2 = 1'b0;
    bus.lat = 1'b0;
    wait_clk(4);
  endtask
  task automatic send_word(logic [31:0] w, int n, bit lat_last);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], lat_last && i == 0);
  endtask
  task automatic sclk1_only();
    bus.sclk1 = 1'b1;
    wait_clk(4);
    bus.sclk1 = 1'b0;
    wait_clk(4);
  endtask
  task automatic pulse_lat();
    bus.lat = 1'b1;
    wait_clk(4);
    bus.lat = 1'b0;
    wait_clk(4);
  endtask
  initial begin
    bus.sclk1 = 1'b0;
    bus.sclk2 = 1'b0;
    bus.lat = 1'b0;
    bus.sdi = 1'b0;
    wait_clk(3);
    check("rst_shift_q", bus.shift_q, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_flags", {bus.dout_vld, bus.frame_err, bus.phase_err}, 0);
    check("rst_bit_cnt", bus.bit_cnt, 0);
    rst_n = 1'b1;
    wait_clk(3);
    // clean frame
    send_word(32'hA5C3, 16, 1'b0);
    check("clean_cnt_pre", bus.bit_cnt, 16);
    check("clean_shift_q", bus.shift_q, 16'hA5C3);
    v0 = vld_cnt;
    pulse_lat();
    check("clean_dout", bus.dout, 16'hA5C3);
    check("clean_vld", vld_cnt - v0, 1);
    check("clean_cnt_post", bus.bit_cnt, 0);
    check("clean_errs", {bus.frame_err, bus.phase_err}, 2'b00);
    // short frame of 12 ones
    send_word(32'hFFF, 12, 1'b0);
    check("short_cnt_pre", bus.bit_cnt, 12);
    v0 = vld_cnt;
    pulse_lat();
    check("short_dout_lo", bus.dout[11:0], 12'hFFF);
    check("short_dout", bus.dout, 16'h3FFF);
    check("short_vld", vld_cnt - v0, 1);
    check("short_frame_err", bus.frame_err, 1);
    check("short_phase_err", bus.phase_err, 0);
    // two SCLK1 pulses without SCLK2, then a full frame
    sclk1_only();
    check("phase_first_s1", bus.phase_err, 0);
    sclk1_only();
    check("phase_second_s1", bus.phase_err, 1);
    send_word(32'h5A5A, 16, 1'b0);
    check("phase_cnt_pre", bus.bit_cnt, 16);
    pulse_lat();
    check("phase_dout", bus.dout, 16'h5A5A);
    check("phase_err_kept", bus.phase_err, 1);
    send_word(32'hC33C, 16, 1'b0);
    pulse_lat();
    check("phase_clean_dout", bus.dout, 16'hC33C);
    check("phase_clean_errs", {bus.frame_err, bus.phase_err}, 2'b00);
    // overrun: 18 bits
    send_word(32'h31234, 18, 1'b0);
    check("over_cnt_pre", bus.bit_cnt, 17);
    check("over_shift_q", bus.shift_q, 16'h1234);
    pulse_lat();
    check("over_dout", bus.dout, 16'h1234);
    check("over_frame_err", bus.frame_err, 1);
    // reset mid-frame after 7 bits
    send_word(32'h7F, 7, 1'b0);
    check("mid_cnt_pre", bus.bit_cnt, 7);
    v0 = vld_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_shift_q", bus.shift_q, 0);
    check("mid_rst_dout", bus.dout, 0);
    check("mid_rst_cnt", bus.bit_cnt, 0);
    check("mid_rst_flags", {bus.dout_vld, bus.frame_err, bus.phase_err}, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    check("mid_rst_no_vld", vld_cnt - v0, 0);
    send_word(32'h00FF, 16, 1'b0);
    v0 = vld_cnt;
    pulse_lat();
    check("post_rst_dout", bus.dout, 16'h00FF);
    check("post_rst_vld", vld_cnt - v0, 1);
    check("post_rst_errs", {bus.frame_err, bus.phase_err}, 2'b00);
    // LAT coincident with the 16th SCLK2
    v0 = vld_cnt;
    send_word(32'h8001, 16, 1'b1);
    check("simul_dout", bus.dout, 16'h8001);
    check("simul_vld", vld_cnt - v0, 1);
    check("simul_cnt", bus.bit_cnt, 0);
    check("simul_errs", {bus.frame_err, bus.phase_err}, 2'b00);
    // LAT with zero bits
    v0 = vld_cnt;
    pulse_lat();
    check("zero_dout", bus.dout, 16'h8001);
    check("zero_vld", vld_cnt - v0, 1);
    check("zero_frame_err", bus.frame_err, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
